// File: rtl/elevator_controller.sv
// SCAN-scheduled N-floor elevator controller with timed travel, door dwell,
// overweight door hold and a latched SOS emergency mode.
module elevator_controller #(
    parameter int FLOORS       = 3,
    parameter int TRAVEL_TICKS = 4,
    parameter int DOOR_TICKS   = 3,
    localparam int FW          = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] floor_buttons,
    input  logic              sos_button,
    input  logic              weight_sensor,
    output logic [FLOORS-1:0] floor_leds,
    output logic [FW-1:0]     current_floor,
    output logic              moving,
    output logic              direction,
    output logic              door_open,
    output logic              sos_led,
    output logic              weight_led,
    output logic              emergency_led
);

    localparam int MAXT = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int CW   = $clog2(MAXT + 1);
    localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_TICKS - 1);
    localparam logic [CW-1:0] DOOR_LAST   = CW'(DOOR_TICKS - 1);

    typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN, EMERGENCY} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [FW-1:0]     floor_n, next_floor;
    logic              dir_n;
    logic [FLOORS-1:0] req, req_n, req_lat;
    logic              emergency, emergency_n;
    logic              sos_q, sos_prev, weight_q;
    logic              sos_edge, set_em, clr_em;
    logic              above, below, beyond, go_up, go_down, call_here;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            current_floor <= '0;
            direction     <= 1'b1;
            req           <= '0;
            emergency     <= 1'b0;
            sos_q         <= 1'b0;
            sos_prev      <= 1'b0;
            weight_q      <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            current_floor <= floor_n;
            direction     <= dir_n;
            req           <= req_n;
            emergency     <= emergency_n;
            sos_q         <= sos_button;
            sos_prev      <= sos_q;
            weight_q      <= weight_sensor;
        end
    end

    // Edge is taken between two registered samples, giving the two-cycle SOS latency.
    assign sos_edge  = sos_q & ~sos_prev;
    assign set_em    = sos_edge & ~emergency;
    assign clr_em    = sos_edge & (state == EMERGENCY);
    assign call_here = floor_buttons[current_floor];

    always_comb begin
        req_lat    = req;
        above      = 1'b0;
        below      = 1'b0;
        beyond     = 1'b0;
        next_floor = direction ? current_floor + FW'(1) : current_floor - FW'(1);
        for (int i = 0; i < FLOORS; i++) begin
            // A call at the floor where the cabin is stopped is served, not stored.
            if (floor_buttons[i] &&
                !(FW'(i) == current_floor && (state == IDLE || state == DOOR_OPEN)))
                req_lat[i] = 1'b1;
            above  = above | (req[i] && (FW'(i) > current_floor));
            below  = below | (req[i] && (FW'(i) < current_floor));
            beyond = beyond | (req_lat[i] &&
                     (direction ? (FW'(i) > next_floor) : (FW'(i) < next_floor)));
        end
        go_up   = above && (direction || !below);
        go_down = below && (!direction || !above);
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        floor_n     = current_floor;
        dir_n       = direction;
        req_n       = req_lat;
        emergency_n = emergency;

        case (state)
            IDLE: begin
                if (set_em) begin
                    state_n = EMERGENCY;
                    cnt_n   = '0;
                end else if (call_here) begin
                    state_n = DOOR_OPEN;
                    cnt_n   = '0;
                end else if (go_up || go_down) begin
                    state_n = MOVING;
                    dir_n   = go_up;
                    cnt_n   = '0;
                end
            end
            MOVING: begin
                if (cnt == TRAVEL_LAST) begin
                    floor_n = next_floor;
                    cnt_n   = '0;
                    if (emergency || set_em) begin
                        state_n = EMERGENCY;
                    end else if (req_lat[next_floor]) begin
                        req_n[next_floor] = 1'b0;
                        state_n           = DOOR_OPEN;
                    end else if (!beyond) begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DOOR_OPEN: begin
                if (set_em) begin
                    state_n = EMERGENCY;
                    cnt_n   = '0;
                end else if (call_here || weight_sensor) begin
                    cnt_n = '0;
                end else if (cnt == DOOR_LAST) begin
                    cnt_n = '0;
                    if (go_up || go_down) begin
                        state_n = MOVING;
                        dir_n   = go_up;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            EMERGENCY: begin
                if (clr_em) begin
                    state_n = DOOR_OPEN;
                    cnt_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase

        if (set_em) emergency_n = 1'b1;
        if (clr_em) emergency_n = 1'b0;
        if (emergency || set_em) req_n = '0;
    end

    assign floor_leds    = req;
    assign moving        = (state == MOVING);
    assign door_open     = (state == DOOR_OPEN) || (state == EMERGENCY);
    assign sos_led       = sos_q;
    assign weight_led    = weight_q;
    assign emergency_led = emergency;

endmodule

// File: tb/tb_elevator_controller.sv
// Directed scenarios plus a randomized run against a cycle-level behavioural model.
module tb_elevator_controller;
    localparam int F  = 3;
    localparam int TT = 4;
    localparam int DT = 3;
    localparam int FW = 2;
    localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2, M_EMER = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [F-1:0]  floor_buttons = '0;
    logic          sos_button = 1'b0;
    logic          weight_sensor = 1'b0;
    logic [F-1:0]  floor_leds;
    logic [FW-1:0] current_floor;
    logic          moving, direction, door_open, sos_led, weight_led, emergency_led;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_mode, m_floor, m_left;
    bit m_up, m_em, m_s1, m_s2, m_w;
    bit m_req[F];

    elevator_controller #(.FLOORS(F), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT)) dut (
        .clk(clk), .reset(reset), .floor_buttons(floor_buttons),
        .sos_button(sos_button), .weight_sensor(weight_sensor),
        .floor_leds(floor_leds), .current_floor(current_floor), .moving(moving),
        .direction(direction), .door_open(door_open), .sos_led(sos_led),
        .weight_led(weight_led), .emergency_led(emergency_led)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = M_IDLE; m_floor = 0; m_left = 0; m_up = 1;
        m_em = 0; m_s1 = 0; m_s2 = 0; m_w = 0;
        for (int i = 0; i < F; i++) m_req[i] = 0;
    endtask

    // SCAN choice: 1 = go up, 0 = go down, -1 = nothing to do
    function automatic int pick();
        bit a = 0, b = 0;
        for (int i = 0; i < F; i++) begin
            if (m_req[i] && i > m_floor) a = 1;
            if (m_req[i] && i < m_floor) b = 1;
        end
        if (a && (m_up || !b)) return 1;
        if (b && (!m_up || !a)) return 0;
        return -1;
    endfunction

    task automatic model_step(input logic [F-1:0] fb, input logic sos, input logic wt);
        bit edge_s, set_em, clr_em, beyond;
        bit nreq[F];
        int p;
        edge_s = m_s1 && !m_s2;
        set_em = edge_s && !m_em;
        clr_em = edge_s && (m_mode == M_EMER);
        for (int i = 0; i < F; i++)
            nreq[i] = m_req[i] || (fb[i] && !(i == m_floor && (m_mode == M_IDLE || m_mode == M_DOOR)));
        p = pick();
        case (m_mode)
            M_IDLE: begin
                if (set_em) m_mode = M_EMER;
                else if (fb[m_floor]) begin m_mode = M_DOOR; m_left = DT; end
                else if (p >= 0) begin m_up = (p == 1); m_mode = M_MOVE; m_left = TT; end
            end
            M_MOVE: begin
                m_left--;
                if (m_left == 0) begin
                    m_floor += m_up ? 1 : -1;
                    if (m_em || set_em) m_mode = M_EMER;
                    else if (nreq[m_floor]) begin
                        nreq[m_floor] = 0; m_mode = M_DOOR; m_left = DT;
                    end else begin
                        beyond = 0;
                        for (int i = 0; i < F; i++)
                            if (nreq[i] && (m_up ? i > m_floor : i < m_floor)) beyond = 1;
                        if (beyond) m_left = TT; else m_mode = M_IDLE;
                    end
                end
            end
            M_DOOR: begin
                if (set_em) m_mode = M_EMER;
                else if (fb[m_floor] || wt) m_left = DT;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (p >= 0) begin m_up = (p == 1); m_mode = M_MOVE; m_left = TT; end
                        else m_mode = M_IDLE;
                    end
                end
            end
            default: if (clr_em) begin m_mode = M_DOOR; m_left = DT; end
        endcase
        if (m_em || set_em) for (int i = 0; i < F; i++) nreq[i] = 0;
        if (set_em) m_em = 1;
        if (clr_em) m_em = 0;
        for (int i = 0; i < F; i++) m_req[i] = nreq[i];
        m_s2 = m_s1; m_s1 = sos; m_w = wt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(floor_buttons, sos_button, weight_sensor);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1; floor_buttons = '0; sos_button = 0; weight_sensor = 0;
        tick(); tick();
        reset = 0;
        model_reset();
    endtask

    // sel: 0 door open, 1 moving, 2 idle (neither)
    task automatic wait_for(input int sel, input int budget, output bit ok);
        ok = 0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if ((sel == 0 && door_open) || (sel == 1 && moving) ||
                (sel == 2 && !door_open && !moving)) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1;
        tick();
        checks++;
        if ({floor_leds, current_floor, moving, direction, door_open, sos_led, weight_led, emergency_led}
            !== {3'b000, 2'd0, 1'b0, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state: got leds=%b floor=%0d mv=%b dir=%b door=%b sos=%b wt=%b em=%b, need 000/0/0/1/0/0/0/0",
                     floor_leds, current_floor, moving, direction, door_open, sos_led, weight_led, emergency_led);
        end
        reset = 0;
        model_reset();
    endtask

    task automatic test_travel();
        floor_buttons = 3'b100; tick(); floor_buttons = '0;
        checks++;
        if (floor_leds !== 3'b100 || moving !== 1'b0) begin
            errors++; $display("FAIL travel_latch: leds=%b mv=%b, need 100/0", floor_leds, moving);
        end
        tick();
        checks++;
        if (moving !== 1'b1 || direction !== 1'b1 || current_floor !== 2'd0) begin
            errors++; $display("FAIL travel_start: mv=%b dir=%b floor=%0d, need 1/1/0", moving, direction, current_floor);
        end
        repeat (3) tick();
        checks++;
        if (current_floor !== 2'd0) begin
            errors++; $display("FAIL travel_early: floor=%0d, need 0", current_floor);
        end
        tick();
        checks++;
        if (current_floor !== 2'd1 || moving !== 1'b1) begin
            errors++; $display("FAIL travel_pass1: floor=%0d mv=%b, need 1/1", current_floor, moving);
        end
        repeat (4) tick();
        checks++;
        if (current_floor !== 2'd2 || door_open !== 1'b1 || moving !== 1'b0 || floor_leds !== 3'b000) begin
            errors++; $display("FAIL travel_arrive: floor=%0d door=%b mv=%b leds=%b, need 2/1/0/000",
                               current_floor, door_open, moving, floor_leds);
        end
        tick(); tick();
        checks++;
        if (door_open !== 1'b1) begin
            errors++; $display("FAIL travel_dwell: door=%b, need 1", door_open);
        end
        tick();
        checks++;
        if (door_open !== 1'b0 || moving !== 1'b0) begin
            errors++; $display("FAIL travel_close: door=%b mv=%b, need 0/0", door_open, moving);
        end
    endtask

    task automatic test_same_floor();
        int bad = 0;
        do_reset();
        floor_buttons = 3'b001;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (door_open !== 1'b1 || floor_leds !== 3'b000) bad++;
        end
        floor_buttons = '0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL same_floor_hold: %0d bad cycles, need 0", bad);
        end
        tick(); tick();
        checks++;
        if (door_open !== 1'b1) begin
            errors++; $display("FAIL same_floor_dwell: door=%b, need 1", door_open);
        end
        tick();
        checks++;
        if (door_open !== 1'b0) begin
            errors++; $display("FAIL same_floor_close: door=%b, need 0", door_open);
        end
    endtask

    task automatic test_weight();
        bit ok;
        int door_cnt, departed;
        do_reset();
        floor_buttons = 3'b010; tick(); floor_buttons = '0;
        wait_for(0, 20, ok);
        checks++;
        if (!ok || current_floor !== 2'd1) begin
            errors++; $display("FAIL weight_reach: ok=%b floor=%0d, need 1/1", ok, current_floor);
        end
        door_cnt = 1; departed = 0;
        weight_sensor = 1; floor_buttons = 3'b100;
        for (int k = 1; k <= 10; k++) begin
            tick();
            floor_buttons = '0;
            if (door_open) door_cnt++;
            if (moving) departed++;
        end
        checks++;
        if (weight_led !== 1'b1 || departed != 0 || floor_leds !== 3'b100) begin
            errors++; $display("FAIL weight_hold: wled=%b departed=%0d leds=%b, need 1/0/100",
                               weight_led, departed, floor_leds);
        end
        weight_sensor = 0;
        tick();
        if (door_open) door_cnt++;
        checks++;
        if (weight_led !== 1'b0) begin
            errors++; $display("FAIL weight_led_off: wled=%b, need 0", weight_led);
        end
        tick();
        if (door_open) door_cnt++;
        tick();
        checks++;
        if (door_cnt != 13 || moving !== 1'b1 || door_open !== 1'b0 || direction !== 1'b1) begin
            errors++; $display("FAIL weight_release: doorcycles=%0d mv=%b door=%b dir=%b, need 13/1/0/1",
                               door_cnt, moving, door_open, direction);
        end
    endtask

    task automatic test_scan();
        bit ok;
        floor_buttons = 3'b001; tick(); floor_buttons = '0;
        checks++;
        if (floor_leds !== 3'b101) begin
            errors++; $display("FAIL scan_latch: leds=%b, need 101", floor_leds);
        end
        wait_for(0, 10, ok);
        checks++;
        if (!ok || current_floor !== 2'd2 || direction !== 1'b1 || floor_leds !== 3'b001) begin
            errors++; $display("FAIL scan_stop2: ok=%b floor=%0d dir=%b leds=%b, need 1/2/1/001",
                               ok, current_floor, direction, floor_leds);
        end
        wait_for(1, 10, ok);
        checks++;
        if (!ok || direction !== 1'b0 || current_floor !== 2'd2) begin
            errors++; $display("FAIL scan_reverse: ok=%b dir=%b floor=%0d, need 1/0/2", ok, direction, current_floor);
        end
        wait_for(0, 20, ok);
        checks++;
        if (!ok || current_floor !== 2'd0 || floor_leds !== 3'b000) begin
            errors++; $display("FAIL scan_stop0: ok=%b floor=%0d leds=%b, need 1/0/000", ok, current_floor, floor_leds);
        end
    endtask

    task automatic test_sos();
        int bad = 0;
        do_reset();
        floor_buttons = 3'b010; tick(); floor_buttons = '0;
        tick(); tick();
        sos_button = 1; tick(); sos_button = 0;
        checks++;
        if (sos_led !== 1'b1 || emergency_led !== 1'b0) begin
            errors++; $display("FAIL sos_register: sled=%b em=%b, need 1/0", sos_led, emergency_led);
        end
        tick();
        checks++;
        if (emergency_led !== 1'b1 || moving !== 1'b1) begin
            errors++; $display("FAIL sos_latch: em=%b mv=%b, need 1/1", emergency_led, moving);
        end
        tick();
        checks++;
        if (moving !== 1'b0 || door_open !== 1'b1 || current_floor !== 2'd1 || floor_leds !== 3'b000) begin
            errors++; $display("FAIL sos_arrive: mv=%b door=%b floor=%0d leds=%b, need 0/1/1/000",
                               moving, door_open, current_floor, floor_leds);
        end
        floor_buttons = 3'b101;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (floor_leds !== 3'b000 || door_open !== 1'b1 || moving !== 1'b0) bad++;
        end
        floor_buttons = '0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL sos_ignore_calls: %0d bad cycles, need 0", bad);
        end
        tick();
        sos_button = 1; tick(); sos_button = 0;
        tick();
        checks++;
        if (emergency_led !== 1'b0 || door_open !== 1'b1 || moving !== 1'b0) begin
            errors++; $display("FAIL sos_clear: em=%b door=%b mv=%b, need 0/1/0", emergency_led, door_open, moving);
        end
        tick(); tick();
        checks++;
        if (door_open !== 1'b1) begin
            errors++; $display("FAIL sos_dwell: door=%b, need 1", door_open);
        end
        tick();
        checks++;
        if (door_open !== 1'b0 || moving !== 1'b0) begin
            errors++; $display("FAIL sos_idle: door=%b mv=%b, need 0/0", door_open, moving);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        do_reset();
        floor_buttons = 3'b100; tick(); floor_buttons = '0;
        wait_for(0, 20, ok);
        wait_for(2, 10, ok);
        floor_buttons = 3'b001; tick(); floor_buttons = '0;
        wait_for(1, 5, ok);
        checks++;
        if (!ok || direction !== 1'b0) begin
            errors++; $display("FAIL areset_setup: ok=%b dir=%b, need 1/0", ok, direction);
        end
        tick(); tick();
        #2 reset = 1;
        #1;
        checks++;
        if ({floor_leds, current_floor, moving, direction, door_open, sos_led, weight_led, emergency_led}
            !== {3'b000, 2'd0, 1'b0, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL async_reset: got leds=%b floor=%0d mv=%b dir=%b door=%b, need 000/0/0/1/0",
                     floor_leds, current_floor, moving, direction, door_open);
        end
        @(negedge clk);
        tick();
        reset = 0;
        model_reset();
    endtask

    task automatic test_random();
        logic [F-1:0] er;
        logic [10:0]  exp_v, got_v;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            floor_buttons = ($urandom_range(0, 5) == 0) ? F'($urandom_range(1, (1 << F) - 1)) : '0;
            sos_button    = ($urandom_range(0, 119) == 0);
            if (!weight_sensor) weight_sensor = ($urandom_range(0, 39) == 0);
            else                weight_sensor = ($urandom_range(0, 3) != 0);
            tick();
            for (int i = 0; i < F; i++) er[i] = m_req[i];
            exp_v = {er, FW'(m_floor), m_mode == M_MOVE, m_up,
                     (m_mode == M_DOOR || m_mode == M_EMER), m_s1, m_w, m_em};
            got_v = {floor_leds, current_floor, moving, direction, door_open, sos_led, weight_led, emergency_led};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random_cycle %0d: got %b need %b (leds,floor,mv,dir,door,sos,wt,em)", c, got_v, exp_v);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_travel();
        test_same_floor();
        test_weight();
        test_scan();
        test_sos();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/elevator_controller.md
# elevator_controller

Parametrised N-floor elevator controller: latches floor-call buttons, schedules travel with a direction-preserving (SCAN) policy, times floor-to-floor travel and door dwell, and handles overweight and SOS emergency modes. It sits under the board top level, clocked by the frequency-divided tick clock `clk`, and drives the per-floor request LEDs plus the status LEDs.

## Interface
- `FLOORS`, 3: number of floors, ≥2; floor indices 0..FLOORS-1.
- `TRAVEL_TICKS`, 4: `clk` cycles to move one floor, ≥1.
- `DOOR_TICKS`, 3: `clk` cycles of door dwell, ≥1.
- `FW` (derived, localparam): $clog2(FLOORS).

- `clk` in 1: system clock; all logic rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `floor_buttons` in FLOORS: call buttons, level, bit i = floor i.
- `sos_button` in 1: SOS push button, level.
- `weight_sensor` in 1: high = cabin overweight.
- `floor_leds` out FLOORS: pending-request register.
- `current_floor` out FW: floor the cabin is at / last passed.
- `moving` out 1: high in MOVING state.
- `direction` out 1: 1 = up, 0 = down.
- `door_open` out 1: high in DOOR_OPEN state.
- `sos_led` out 1: registered copy of `sos_button`.
- `weight_led` out 1: registered copy of `weight_sensor`.
- `emergency_led` out 1: high while emergency mode is latched.

## Operation
- States: IDLE, MOVING, DOOR_OPEN, EMERGENCY. Reset: IDLE, `current_floor`=0, `direction`=1, requests=0, counters=0, emergency=0; all outputs 0 except `direction`=1.
- Request latch: any cycle with `floor_buttons[i]`=1 sets req[i], except when i==`current_floor` and state is IDLE or DOOR_OPEN (served immediately, bit stays 0). Bits clear only on service at arrival or on emergency entry.
- "Above"/"below" = any req bit at index >/< `current_floor`.
- Direction choice (IDLE, and at door-close): up if above and (`direction`=1 or none below); down if below and (`direction`=0 or none above); else stay idle.
- IDLE: call at current floor → DOOR_OPEN next cycle; else if a direction is chosen → MOVING, travel counter 0.
- MOVING: counter 0..TRAVEL_TICKS-1; at terminal count `current_floor` ±1 per `direction`. If req at new floor → clear bit, DOOR_OPEN; else continue (counter to 0). `current_floor` never leaves 0..FLOORS-1.
- DOOR_OPEN: counter 0..DOOR_TICKS-1. A call at current floor, or `weight_sensor`=1, restarts counter at 0. At terminal with `weight_sensor`=0: apply direction choice → MOVING or IDLE.
- SOS: rising edge of `sos_button` (vs. its registered copy) sets emergency. From IDLE/DOOR_OPEN → EMERGENCY next cycle; from MOVING the current segment completes, then EMERGENCY at arrival. Entry clears all req bits; new calls ignored while emergency is set.
- EMERGENCY: `door_open`=1, `moving`=0. Next SOS rising edge clears emergency → DOOR_OPEN with counter 0.
- `emergency_led` = emergency flag (set from the edge cycle, including during segment completion).

## Timing
- Button to `floor_leds`: 1 cycle.
- IDLE call at adjacent floor: MOVING 1 cycle after latch, arrival/DOOR_OPEN TRAVEL_TICKS cycles later.
- Door dwell without disturbance: exactly DOOR_TICKS cycles of `door_open`.
- SOS edge to `emergency_led`: 2 cycles (register + edge detect).
- Simultaneous: a call at the arrival floor in the arrival cycle is served by that stop; SOS edge coinciding with MOVING terminal count → EMERGENCY at that floor.
- Mid-operation reset returns to reset state immediately, regardless of clock.

## Test plan
- Reset, press floor 2 for 1 cycle (FLOORS=3, TRAVEL_TICKS=4, DOOR_TICKS=3) → `floor_leds`=100, moving up, floor 1 after 4 cycles, floor 2 after 8, `door_open` 3 cycles, `floor_leds`=000, IDLE.
- Floor 0 idle, press 0 → `door_open` next cycle, `floor_leds` stays 000; hold 0 for 5 cycles → door stays open until 3 cycles after release.
- Door open at floor 1, `weight_sensor`=1 for 10 cycles → door open ≥13 cycles, `weight_led`=1, no departure while high.
- At floor 1 moving up to 2, press floor 0 → stops at 2, then goes down to 0 (SCAN order), `direction` toggles after the door at 2 closes.
- Moving 0→1, SOS pulse at travel count 1 → segment completes, floor 1, EMERGENCY, `floor_leds`=000, presses ignored; second SOS pulse → DOOR_OPEN 3 cycles, IDLE.
- Assert `reset` mid-travel → all outputs to reset values asynchronously, `direction`=1.
